// File: rtl/onchip_mem_arb_pkg.sv
// Shared constants for the two-port on-chip memory arbiter.
// Holds width defaults, port indices and the statistics counter width.
package onchip_mem_arb_pkg;

  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 32;
  localparam int CNT_W      = 16;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/onchip_mem_arb_rr2.sv
// Two-way round-robin grant.
// Ports: req_i (per-port request), last_grant_i (index last served),
// grant_o (one-hot winner, zero when no request).
module onchip_mem_arb_rr2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // On a tie, the port that was not served last wins.
  assign grant_o[0] = req_i[0] & (~req_i[1] | last_grant_i);
  assign grant_o[1] = req_i[1] & (~req_i[0] | ~last_grant_i);

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-requester arbiter in front of a single-port RAM, 1-cycle read latency.
// Ports: clk, reset (async, active high); per requester mX_address,
// mX_byteenable, mX_read, mX_write, mX_writedata in and mX_waitrequest,
// mX_readdata, mX_readdatavalid out; mem_* drive the RAM, mem_readdata
// returns from it. Build macro ONCHIP_MEM_ARB_STATS_EN adds saturating
// per-port accept counters m0_grant_count / m1_grant_count.
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
`ifdef ONCHIP_MEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  m0_grant_count,
  output logic [CNT_W-1:0]  m1_grant_count
`endif
);

  logic [1:0] req;
  logic [1:0] grant;
  logic       accept;
  logic       win_rd;
  logic       win_wr;

  logic last_grant_q, last_grant_d;
  logic rd_valid_q, rd_valid_d;
  logic rd_port_q, rd_port_d;

  // Nothing is accepted while reset is held.
  assign req[0] = (m0_read | m0_write) & ~reset;
  assign req[1] = (m1_read | m1_write) & ~reset;

  onchip_mem_arb_rr2 u_rr2 (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  assign accept = |grant;
  assign win_wr = grant[1] ? m1_write : m0_write;
  assign win_rd = grant[1] ? m1_read  : m0_read;

  assign mem_address    = grant[1] ? m1_address    : m0_address;
  assign mem_byteenable = grant[1] ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = grant[1] ? m1_writedata  : m0_writedata;
  assign mem_chipselect = accept;
  assign mem_write      = accept & win_wr;
  assign mem_clken      = 1'b1;

  assign m0_waitrequest = reset | (req[0] & ~grant[0]);
  assign m1_waitrequest = reset | (req[1] & ~grant[1]);

  // Read+write together on one port is handled as a write.
  always_comb begin
    last_grant_d = last_grant_q;
    rd_valid_d   = accept & win_rd & ~win_wr;
    rd_port_d    = rd_port_q;
    if (accept) begin
      last_grant_d = grant[1];
    end
    if (rd_valid_d) begin
      rd_port_d = grant[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= PORT1;
      rd_valid_q   <= 1'b0;
      rd_port_q    <= PORT0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_valid_q   <= rd_valid_d;
      rd_port_q    <= rd_port_d;
    end
  end

  // RAM output is shared; the valid strobe carries the routing.
  assign m0_readdata = mem_readdata;
  assign m1_readdata = mem_readdata;

  assign m0_readdatavalid = rd_valid_q & (rd_port_q == PORT0) & ~reset;
  assign m1_readdatavalid = rd_valid_q & (rd_port_q == PORT1) & ~reset;

`ifdef ONCHIP_MEM_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (grant[0] && cnt0_q != {CNT_W{1'b1}}) begin
      cnt0_d = cnt0_q + 1'b1;
    end
    if (grant[1] && cnt1_q != {CNT_W{1'b1}}) begin
      cnt1_d = cnt1_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign m0_grant_count = cnt0_q;
  assign m1_grant_count = cnt1_q;
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Self-checking bench for onchip_mem_arbiter with a behavioural RAM
// and reference model. Define ONCHIP_MEM_ARB_STATS_EN for counter tests.
module tb_onchip_mem_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] m0_address, m1_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic [DW-1:0] mem_writedata;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_readdata;
`ifdef ONCHIP_MEM_ARB_STATS_EN
  logic [15:0]   m0_grant_count, m1_grant_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_writedata    (mem_writedata),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
`ifdef ONCHIP_MEM_ARB_STATS_EN
    ,
    .m0_grant_count   (m0_grant_count),
    .m1_grant_count   (m1_grant_count)
`endif
  );

  // Behavioural single-port RAM: 1-cycle registered read.
  logic [DW-1:0] ram [int];
  logic [DW-1:0] rdq = '0;
  assign mem_readdata = rdq;

  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        logic [DW-1:0] w;
        w = ram.exists(int'(mem_address)) ? ram[int'(mem_address)] : '0;
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) w[8*b +: 8] = mem_writedata[8*b +: 8];
        ram[int'(mem_address)] = w;
      end else begin
        rdq <= ram.exists(int'(mem_address)) ? ram[int'(mem_address)] : '0;
      end
    end
  end

  // Reference memory contents for the random test.
  logic [DW-1:0] mdl [int];

  function automatic logic [DW-1:0] mrd(int a);
    return mdl.exists(a) ? mdl[a] : '0;
  endfunction

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_address = '0; m1_address = '0;
    m0_byteenable = '0; m1_byteenable = '0;
    m0_writedata = '0; m1_writedata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1;
    m0_read = 1; m1_read = 1;
    #1;
    tests++;
    if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
      fails++;
      $display("FAIL rst_wait got %b%b want 11",
               m0_waitrequest, m1_waitrequest);
    end
    tests++;
    if (mem_chipselect !== 1'b0) begin
      fails++;
      $display("FAIL rst_cs got %b want 0", mem_chipselect);
    end
    tests++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      fails++;
      $display("FAIL rst_rdv got %b%b want 00",
               m0_readdatavalid, m1_readdatavalid);
    end
    @(negedge clk);
    idle();
    reset = 0;
    #1;
    tests++;
    if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b0) begin
      fails++;
      $display("FAIL idle_wait got %b%b want 00",
               m0_waitrequest, m1_waitrequest);
    end
    @(negedge clk);
    tests++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      fails++;
      $display("FAIL idle_rdv got %b%b want 00",
               m0_readdatavalid, m1_readdatavalid);
    end
  endtask

  task automatic p0_write(input logic [AW-1:0] a,
                          input logic [DW-1:0] d,
                          input logic [BW-1:0] be);
    @(negedge clk);
    idle();
    m0_write = 1; m0_address = a; m0_writedata = d; m0_byteenable = be;
    #1;
    tests++;
    if (m0_waitrequest !== 1'b0 || mem_write !== 1'b1) begin
      fails++;
      $display("FAIL wr_accept wait=%b mem_write=%b want 0/1",
               m0_waitrequest, mem_write);
    end
  endtask

  task automatic p0_read_check(input logic [AW-1:0] a,
                               input logic [DW-1:0] exp, input string nm);
    @(negedge clk);
    tests++;
    if (m0_readdatavalid !== 1'b0) begin
      fails++;
      $display("FAIL %s_wr_no_rdv got %b want 0", nm, m0_readdatavalid);
    end
    idle();
    m0_read = 1; m0_address = a;
    #1;
    tests++;
    if (m0_waitrequest !== 1'b0) begin
      fails++;
      $display("FAIL %s_rd_wait got %b want 0", nm, m0_waitrequest);
    end
    @(negedge clk);
    idle();
    tests++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== exp) begin
      fails++;
      $display("FAIL %s rdv=%b data=%h want 1/%h",
               nm, m0_readdatavalid, m0_readdata, exp);
    end
    @(negedge clk);
    tests++;
    if (m0_readdatavalid !== 1'b0) begin
      fails++;
      $display("FAIL %s_pulse got %b want 0", nm, m0_readdatavalid);
    end
  endtask

  task automatic test_write_read();
    p0_write(14'h0010, 32'hDEADBEEF, 4'hF);
    p0_read_check(14'h0010, 32'hDEADBEEF, "wr_rd");
  endtask

  task automatic test_byte_enable();
    p0_write(14'h0020, 32'hFFFFFFFF, 4'hF);
    p0_write(14'h0020, 32'h00000000, 4'h2);
    p0_read_check(14'h0020, 32'hFFFF00FF, "byte_en");
  endtask

  task automatic test_alternate();
    int n0 = 0;
    int n1 = 0;
    do_reset();
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        logic exp_p;
        exp_p = ((i - 1) % 2) == 1;
        if (m0_readdatavalid) n0++;
        if (m1_readdatavalid) n1++;
        tests++;
        if (m0_readdatavalid !== !exp_p || m1_readdatavalid !== exp_p ||
            mem_readdata !== (exp_p ? 32'hFFFF00FF : 32'hDEADBEEF)) begin
          fails++;
          $display("FAIL alt_rsp%0d rdv=%b%b data=%h want port %0d",
                   i, m1_readdatavalid, m0_readdatavalid,
                   mem_readdata, exp_p);
        end
      end
      if (i < 8) begin
        m0_read = 1; m0_address = 14'h0010;
        m1_read = 1; m1_address = 14'h0020;
        #1;
        tests++;
        if (m0_waitrequest !== (i % 2 == 1) ||
            m1_waitrequest !== (i % 2 == 0)) begin
          fails++;
          $display("FAIL alt_grant%0d wait=%b%b want winner %0d",
                   i, m1_waitrequest, m0_waitrequest, i % 2);
        end
      end else begin
        idle();
      end
    end
    tests++;
    if (n0 != 4 || n1 != 4) begin
      fails++;
      $display("FAIL alt_count got %0d/%0d want 4/4", n0, n1);
    end
  endtask

  task automatic test_reset_inflight();
    int bad = 0;
    @(negedge clk);
    idle();
    m1_read = 1; m1_address = 14'h0020;
    #1;
    tests++;
    if (m1_waitrequest !== 1'b0) begin
      fails++;
      $display("FAIL inflight_accept got %b want 0", m1_waitrequest);
    end
    @(posedge clk);
    #1;
    reset = 1;
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (m1_readdatavalid !== 1'b0 || m0_readdatavalid !== 1'b0) bad++;
    end
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (m1_readdatavalid !== 1'b0 || m0_readdatavalid !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL inflight_drop got %0d pulses want 0", bad);
    end
    m0_read = 1; m1_read = 1;
    #1;
    tests++;
    if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
      fails++;
      $display("FAIL post_rst_tie wait=%b%b want 10",
               m1_waitrequest, m0_waitrequest);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_random();
    logic          last = 1'b1;
    logic          pend = 1'b0;
    logic          pend_p = 1'b0;
    logic [DW-1:0] pend_d = '0;
    do_reset();
    for (int c = 0; c <= 300; c++) begin
      @(negedge clk);
      tests++;
      if (m0_readdatavalid !== (pend && !pend_p) ||
          m1_readdatavalid !== (pend && pend_p) ||
          (pend && mem_readdata !== pend_d)) begin
        fails++;
        $display("FAIL rnd_rsp c=%0d rdv=%b%b data=%h want p%0d v%b %h",
                 c, m1_readdatavalid, m0_readdatavalid, mem_readdata,
                 pend_p, pend, pend_d);
      end
      pend = 1'b0;
      if (c == 300) begin
        idle();
        break;
      end
      begin
        logic [3:0] r;
        logic       q0, q1, win, has;
        logic       wrn, rdn;
        int         a;
        logic [DW-1:0] wd;
        logic [BW-1:0] be;
        r = 4'($urandom);
        m0_read = r[0]; m0_write = r[1];
        m1_read = r[2]; m1_write = r[3];
        m0_address = AW'(14'h0100 + $urandom_range(0, 7));
        m1_address = AW'(14'h0100 + $urandom_range(0, 7));
        m0_writedata = $urandom; m1_writedata = $urandom;
        m0_byteenable = 4'($urandom); m1_byteenable = 4'($urandom);
        q0 = m0_read || m0_write;
        q1 = m1_read || m1_write;
        has = q0 || q1;
        win = (q0 && q1) ? !last : q1;
        #1;
        tests++;
        if (m0_waitrequest !== (q0 && win) ||
            m1_waitrequest !== (q1 && !win) ||
            mem_chipselect !== has) begin
          fails++;
          $display("FAIL rnd_arb c=%0d wait=%b%b cs=%b want %b%b %b",
                   c, m1_waitrequest, m0_waitrequest, mem_chipselect,
                   q1 && !win, q0 && win, has);
        end
        if (has) begin
          wrn = win ? m1_write : m0_write;
          rdn = win ? m1_read : m0_read;
          a   = win ? int'(m1_address) : int'(m0_address);
          wd  = win ? m1_writedata : m0_writedata;
          be  = win ? m1_byteenable : m0_byteenable;
          last = win;
          if (wrn) begin
            logic [DW-1:0] w;
            w = mrd(a);
            for (int b = 0; b < BW; b++)
              if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
            mdl[a] = w;
          end else if (rdn) begin
            pend = 1'b1;
            pend_p = win;
            pend_d = mrd(a);
          end
        end
      end
    end
  endtask

`ifdef ONCHIP_MEM_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    @(negedge clk);
    tests++;
    if (m0_grant_count !== 16'h0 || m1_grant_count !== 16'h0) begin
      fails++;
      $display("FAIL cnt_reset got %h/%h want 0/0",
               m0_grant_count, m1_grant_count);
    end
    m0_read = 1; m0_address = 14'h0010;
    repeat (70000) @(negedge clk);
    idle();
    tests++;
    if (m0_grant_count !== 16'hFFFF || m1_grant_count !== 16'h0) begin
      fails++;
      $display("FAIL cnt_sat got %h/%h want ffff/0",
               m0_grant_count, m1_grant_count);
    end
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_byte_enable();
    test_alternate();
    test_reset_inflight();
    test_random();
`ifdef ONCHIP_MEM_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14: word-address width shared by both ports and the memory port.
REQ-002 Parameter DATA_W, default 32: data width; BE_W = DATA_W/8 byte enables.
REQ-003 Port clk, input, 1: single clock for all logic.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Ports mX_address (X=0,1), input, ADDR_W: requester word address.
REQ-006 Ports mX_byteenable, input, BE_W: write byte lanes.
REQ-007 Ports mX_read / mX_write, input, 1 each: request strobes; both high on one port is illegal.
REQ-008 Ports mX_writedata, input, DATA_W: write data.
REQ-009 Ports mX_waitrequest, output, 1: high means the request was not accepted this cycle.
REQ-010 Ports mX_readdata, output, DATA_W: read data, meaningful only with readdatavalid.
REQ-011 Ports mX_readdatavalid, output, 1: one-cycle pulse per accepted read.
REQ-012 Ports mem_address / mem_byteenable / mem_writedata, output, ADDR_W / BE_W / DATA_W: to the single-port RAM.
REQ-013 Ports mem_chipselect, mem_write, mem_clken, output, 1 each: RAM controls.
REQ-014 Port mem_readdata, input, DATA_W: RAM output, unregistered after the RAM's internal address register.

Function
REQ-015 At most one request SHALL be presented to the RAM per cycle; accepted means mX_waitrequest low while mX_read or mX_write is high.
REQ-016 Single requester active: it SHALL be accepted the same cycle (zero wait).
REQ-017 Both active: the port not granted most recently SHALL win; loser waitrequest high; last_grant register updates only on an accepted request.
REQ-018 last_grant reset value SHALL be 1, so port 0 wins the first tie.
REQ-019 Idle port: waitrequest SHALL be low (no request, nothing to stall).
REQ-020 mem_* outputs SHALL be a combinational mux of the winner; mem_chipselect = any accept; mem_write = winner's write; mem_clken held 1.
REQ-021 Read latency SHALL be exactly 1: readdatavalid and readdata = mem_readdata on the winning port the cycle after acceptance.
REQ-022 Back-to-back reads (either port, alternating or not) SHALL sustain 1 access/cycle; a 1-bit valid pipeline plus 1-bit port tag route responses.
REQ-023 Write accepted in the same cycle a prior read returns data SHALL NOT disturb that response.
REQ-024 Writes SHALL generate no readdatavalid.
REQ-025 Illegal read+write on one port SHALL be treated as write.
REQ-026 No idle state: arbitration fully pipelined; sequential state = last_grant, rd_valid_q, rd_port_q (plus counters, REQ-030).

Reset
REQ-027 During reset: rd_valid_q=0, rd_port_q=0, last_grant=1, counters=0; both readdatavalid outputs low.
REQ-028 Reset asserted with a read in flight SHALL drop the response; no readdatavalid after reset release.
REQ-029 Request acceptance SHALL be blocked (waitrequest high, mem_chipselect low) while reset is high.

Configuration
REQ-030 Macro ONCHIP_MEM_ARB_STATS_EN defined: outputs m0_grant_count, m1_grant_count (16 bits each) count accepted requests per port, saturating at 0xFFFF; undefined: ports and counters absent, behaviour otherwise identical.

Structure
REQ-031 Package onchip_mem_arb_pkg SHALL hold the DATA_W/ADDR_W defaults, the port-index constants, and the counter width constant (16).
REQ-032 One sub-module onchip_mem_arb_rr2 SHALL implement the 2-way round-robin grant (requests + last_grant in, one-hot grant out).

Verification
REQ-033 Port 0 write 0xDEADBEEF to addr 0x0010 with byteenable 0xF, then port 0 read of 0x0010 -> readdatavalid 1 cycle after acceptance, data 0xDEADBEEF.
REQ-034 Both ports read every cycle for 8 cycles after reset -> grants alternate 0,1,0,1...; each port gets 4 readdatavalid pulses, correctly tagged.
REQ-035 Write 0xFFFFFFFF, then 0x00000000 with byteenable 0x2, then read -> 0xFFFF00FF.
REQ-036 Accept read on port 1, assert reset the next edge -> port 1 readdatavalid never asserts; after release port 0 wins the first tie.
REQ-037 With ONCHIP_MEM_ARB_STATS_EN, 70000 port-0 accepts -> m0_grant_count = 0xFFFF, m1_grant_count = 0.
